fft_seq_ctrl: RTL
=================

# fft_seq_ctrl

Top-level sequencer for the 256-point radix-2 FFT core. Accepts a frame of input samples, runs the in-place butterfly stages over the shared sample RAM, then streams results out in natural order. It drives RAM addresses, butterfly issue strobes and twiddle-ROM addresses; it owns no sample data.

## Interface
- N_LOG2, 8: log2 of FFT length (N = 256)
- BF_LAT, 4: cycles from `bf_issue` to butterfly write-back into RAM; legal range 1..15
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  input sample present
- in_ready  out  1  controller accepting input sample
- in_wr_en  out  1  write strobe to sample RAM (= in_valid & in_ready)
- in_wr_addr  out  N_LOG2  bit-reversed input index
- bf_issue  out  1  butterfly issue strobe
- bf_addr_a  out  N_LOG2  top-leg RAM address
- bf_addr_b  out  N_LOG2  bottom-leg RAM address
- tw_addr  out  N_LOG2-1  twiddle ROM index
- out_ready  in  1  downstream credit for one output sample
- out_rd_en  out  1  RAM read strobe for output
- out_rd_addr  out  N_LOG2  natural-order output index
- out_valid  out  1  RAM read data valid (out_rd_en delayed 1 cycle)
- stage  out  3  current butterfly stage 0..7
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, LOAD, CALC, DRAIN, UNLOAD, FLUSH, DONE.
- IDLE: all strobes low. `start`=1 -> LOAD, index counter cleared.
- LOAD: `in_ready`=1. Each accepted sample i (0..255) writes to `in_wr_addr` = bitrev8(i). After i=255 accepted -> CALC, stage=0, k=0.
- CALC: `bf_issue`=1 every cycle, k = 0..127. For stage s: span = 1<<s, grp = k>>s, pos = k & (span-1); `bf_addr_a` = (grp<<(s+1)) | pos; `bf_addr_b` = a + span; `tw_addr` = pos << (7-s). After k=127 -> DRAIN.
- DRAIN: no issue for BF_LAT cycles (read-after-write hazard across stages). Then if stage<7: stage+1, k=0 -> CALC; else -> UNLOAD.
- UNLOAD: `out_rd_en` = `out_ready`; address 0..255, advances only on issued read. After read 255 issued -> FLUSH.
- FLUSH: one cycle, lets last `out_valid` appear -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- All address/index counters are N_LOG2 bits; wrap from 255 to 0 is never used as a state transition trigger; terminal counts are compared explicitly.
- `start` outside IDLE ignored; `start` during the DONE cycle ignored.
- `in_valid` outside LOAD ignored (`in_ready`=0).
- Downstream contract: `out_valid` is not back-pressurable; asserting `out_ready` commits the sink to take data the next cycle.

## Timing
- Reset: state IDLE; `stage`, counters 0; `in_ready`, `in_wr_en`, `bf_issue`, `out_rd_en`, `out_valid`, `busy`, `done` = 0; address outputs 0.
- `rst` mid-frame: next cycle in IDLE with reset values; RAM contents undefined, no flush.
- `busy` rises the cycle after `start` is sampled.
- LOAD with continuous `in_valid`: 256 cycles. CALC+DRAIN: 8*(128+BF_LAT) cycles. UNLOAD with continuous `out_ready`: 256 cycles + FLUSH 1 + DONE 1.
- Minimum frame start-to-done: 256 + 8*(128+BF_LAT) + 258 cycles (1570 at BF_LAT=4).
- All outputs registered except `in_ready`, `in_wr_en`, `out_rd_en` (combinational from state and handshake inputs).

## Structure
- Package `fft_ctrl_pkg`: state enum, `N_LOG2`, `N`, `N_BF` (= N/2), bitrev function.
- Sub-module `fft_addr_gen`: combinational (stage, k) -> (`bf_addr_a`, `bf_addr_b`, `tw_addr`), registered at its outputs in the parent.

## Test plan
- Reset then `start` with 256 back-to-back inputs -> `in_wr_addr` sequence 0,128,64,192,…,255; CALC entered cycle after input 255.
- Stage 0 -> k=0 gives a=0,b=1,tw=0; stage 7, k=5 -> a=5,b=133,tw=5; stage 3, k=9 -> a=17,b=25,tw=16.
- BF_LAT=4: exactly 4 idle cycles between last issue of stage s and first issue of stage s+1; `done` 1570 cycles after start.
- `out_ready` toggling 1,0,1,0 -> `out_rd_addr` advances only on ready cycles; `out_valid` trails `out_rd_en` by 1; 256 valids total.
- `start` pulsed during CALC and on the `done` cycle -> ignored; `in_valid` during CALC -> no `in_wr_en`.
- `rst` asserted mid-CALC (stage 4) -> next cycle IDLE, all strobes 0, `stage`=0; new `start` runs a clean frame.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the 256-point radix-2 FFT sequencer.
//   - fsm_state_e : sequencer states
//   - N_LOG2, N, N_BF : FFT size constants
//   - bitrev()    : N_LOG2-bit bit reversal used for input scatter
package fft_ctrl_pkg;

  localparam int N_LOG2 = 8;
  localparam int N      = 1 << N_LOG2;
  localparam int N_BF   = N / 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4,
    S_FLUSH  = 3'd5,
    S_DONE   = 3'd6
  } fsm_state_e;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator (purely combinational).
// Ports:
//   stage   in  : butterfly stage s (0..7)
//   k       in  : butterfly index within the stage (0..127)
//   addr_a  out : top-leg RAM address  = (grp << (s+1)) | pos
//   addr_b  out : bottom-leg RAM address = addr_a + span
//   tw_addr out : twiddle ROM index    = pos << (7-s)
// with span = 1<<s, grp = k>>s, pos = k & (span-1).
module fft_addr_gen
  import fft_ctrl_pkg::*;
(
  input  logic [2:0]        stage,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_addr
);

  logic [N_LOG2-1:0] k_ext;
  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] mask;
  logic [N_LOG2-1:0] grp;
  logic [N_LOG2-1:0] pos;
  logic [3:0]        grp_shift;

  always_comb begin
    k_ext     = {1'b0, k};
    span      = N_LOG2'(1) << stage;
    mask      = span - N_LOG2'(1);
    grp       = k_ext >> stage;
    pos       = k_ext & mask;
    // Widened so that s+1 does not wrap to 0 at the last stage.
    grp_shift = {1'b0, stage} + 4'd1;
    addr_a    = (grp << grp_shift) | pos;
    // Bit s of addr_a is always 0, so OR-ing span is the same as adding it.
    addr_b    = addr_a | span;
    tw_addr   = pos[N_LOG2-2:0] << (3'(N_LOG2 - 1) - stage);
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Top-level sequencer of the 256-point radix-2 FFT core.
// Loads a frame (bit-reversed scatter), runs 8 in-place butterfly stages with
// a BF_LAT-cycle drain between stages, then streams results in natural order.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a frame (only sampled in IDLE)
//   in_valid/in_ready   : input handshake; in_wr_en = in_valid & in_ready
//   in_wr_addr          : bit-reversed RAM write address
//   bf_issue, bf_addr_a, bf_addr_b, tw_addr : butterfly issue port
//   out_ready           : sink credit; out_rd_en = out_ready while UNLOAD
//   out_rd_addr         : natural-order RAM read address
//   out_valid           : out_rd_en delayed one cycle (RAM read latency)
//   stage, busy, done   : status
// Handshakes: a transfer happens in any cycle where both sides of the pair are
// high (in_valid & in_ready, or out_rd_en); in_ready/in_wr_en/out_rd_en are
// combinational from the state and the input, all other outputs are registered
// and line up with the state the FSM is in during that cycle.
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              in_wr_en,
  output logic [N_LOG2-1:0] in_wr_addr,
  output logic              bf_issue,
  output logic [N_LOG2-1:0] bf_addr_a,
  output logic [N_LOG2-1:0] bf_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  input  logic              out_ready,
  output logic              out_rd_en,
  output logic [N_LOG2-1:0] out_rd_addr,
  output logic              out_valid,
  output logic [2:0]        stage,
  output logic              busy,
  output logic              done
);

  fsm_state_e        state_q, state_d;
  logic [N_LOG2-1:0] idx_q, idx_d;     // load / unload sample index
  logic [N_LOG2-2:0] k_q, k_d;         // butterfly index within a stage
  logic [3:0]        lat_q, lat_d;     // drain cycle counter
  logic [2:0]        stage_q, stage_d;

  logic [N_LOG2-1:0] in_wr_addr_q, out_rd_addr_q;
  logic [N_LOG2-1:0] bf_addr_a_q, bf_addr_b_q;
  logic [N_LOG2-2:0] tw_addr_q;
  logic              bf_issue_q, out_valid_q, busy_q, done_q;

  logic [N_LOG2-1:0] gen_a, gen_b;
  logic [N_LOG2-2:0] gen_tw;

  // Fed with next-state values so the registered addresses line up with
  // the cycle in which bf_issue is high.
  fft_addr_gen u_addr_gen (
    .stage   (stage_d),
    .k       (k_d),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    lat_d     = lat_q;
    stage_d   = stage_q;
    in_ready  = 1'b0;
    out_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          k_d     = '0;
          stage_d = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx_q == N_LOG2'(N - 1)) begin
            state_d = S_CALC;
            idx_d   = '0;
            k_d     = '0;
            stage_d = '0;
          end else begin
            idx_d = idx_q + N_LOG2'(1);
          end
        end
      end
      S_CALC: begin
        if (k_q == (N_LOG2 - 1)'(N_BF - 1)) begin
          state_d = S_DRAIN;
          lat_d   = '0;
        end else begin
          k_d = k_q + (N_LOG2 - 1)'(1);
        end
      end
      S_DRAIN: begin
        // Lets the last write-backs of this stage land before the next
        // stage reads them.
        if (lat_q == 4'(BF_LAT - 1)) begin
          if (stage_q == 3'(N_LOG2 - 1)) begin
            state_d = S_UNLOAD;
            idx_d   = '0;
          end else begin
            state_d = S_CALC;
            stage_d = stage_q + 3'd1;
            k_d     = '0;
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_UNLOAD: begin
        out_rd_en = out_ready;
        if (out_ready) begin
          if (idx_q == N_LOG2'(N - 1)) begin
            state_d = S_FLUSH;
          end else begin
            idx_d = idx_q + N_LOG2'(1);
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_wr_en = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      k_q           <= '0;
      lat_q         <= '0;
      stage_q       <= '0;
      in_wr_addr_q  <= '0;
      out_rd_addr_q <= '0;
      bf_addr_a_q   <= '0;
      bf_addr_b_q   <= '0;
      tw_addr_q     <= '0;
      bf_issue_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      lat_q       <= lat_d;
      stage_q     <= stage_d;
      bf_issue_q  <= (state_d == S_CALC);
      out_valid_q <= out_rd_en;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      if (state_d == S_LOAD) begin
        in_wr_addr_q <= bitrev(idx_d);
      end
      if (state_d == S_UNLOAD) begin
        out_rd_addr_q <= idx_d;
      end
      if (state_d == S_CALC) begin
        bf_addr_a_q <= gen_a;
        bf_addr_b_q <= gen_b;
        tw_addr_q   <= gen_tw;
      end
    end
  end

  assign in_wr_addr  = in_wr_addr_q;
  assign bf_issue    = bf_issue_q;
  assign bf_addr_a   = bf_addr_a_q;
  assign bf_addr_b   = bf_addr_b_q;
  assign tw_addr     = tw_addr_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_valid   = out_valid_q;
  assign stage       = stage_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
